// File: rtl/gbc_video_pkg.sv
// Shared GBC video types: OAM DMA state encoding, register/OAM constants
// and the echo-RAM source page remap (GBC_OAM_DMA_ECHO_EN).
package gbc_video_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    READ,
    WRITE,
    WAIT
  } oam_dma_state_t;

  localparam logic [7:0]  OAM_DMA_REG_ADDR = 8'h46;
  localparam logic [15:0] OAM_BASE         = 16'hFE00;

  // Pages $E0-$FF alias work RAM at page-$20 when echo is enabled.
  function automatic logic [7:0] oam_dma_src_page(
    input logic [7:0] page
  );
`ifdef GBC_OAM_DMA_ECHO_EN
    if (page >= 8'hE0)
      return page - 8'h20;
    else
      return page;
`else
    return page;
`endif
  endfunction

endpackage

// File: rtl/gbc_oam_dma_if.sv
// OAM DMA bus bundle: Wishbone source read (SrcCyc/SrcStb/SrcAdr/SrcAck/
// SrcDat) and OAM write port (OamWe/OamAdr/OamDat). master = DMA engine.
interface gbc_oam_dma_if;

  logic        SrcCyc;
  logic        SrcStb;
  logic [15:0] SrcAdr;
  logic        SrcAck;
  logic [7:0]  SrcDat;
  logic        OamWe;
  logic [7:0]  OamAdr;
  logic [7:0]  OamDat;

  modport master (
    output SrcCyc, SrcStb, SrcAdr,
    output OamWe, OamAdr, OamDat,
    input  SrcAck, SrcDat
  );

  modport slave (
    input  SrcCyc, SrcStb, SrcAdr,
    input  OamWe, OamAdr, OamDat,
    output SrcAck, SrcDat
  );

endinterface

// File: rtl/gbc_oam_dma.sv
// OAM DMA engine: $FF46 write copies page XX00-XX9F into OAM, one byte per
// ClkEn. Ports: CLK, RST (async low), ClkEn, RegWe/RegWData/RegRData,
// DmaActive, bus (gbc_oam_dma_if.master). Option: GBC_OAM_DMA_ECHO_EN.
module gbc_oam_dma
  import gbc_video_pkg::*;
#(
  parameter int OAM_BYTES   = 160,
  parameter int START_DELAY = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ClkEn,
  input  logic          RegWe,
  input  logic [7:0]    RegWData,
  output logic [7:0]    RegRData,
  output logic          DmaActive,
  gbc_oam_dma_if.master bus
);

  localparam logic [7:0] IDX_LAST = 8'(OAM_BYTES - 1);
  localparam logic [7:0] DLY_LAST = 8'(START_DELAY - 1);

  oam_dma_state_t state;

  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  dly;
  logic        cyc;
  logic [15:0] adr;
  logic        we;
  logic [7:0]  oadr;
  logic [7:0]  odat;
  logic        act;

  assign bus.SrcCyc = cyc;
  assign bus.SrcStb = cyc;
  assign bus.SrcAdr = adr;
  assign bus.OamWe  = we;
  assign bus.OamAdr = oadr;
  assign bus.OamDat = odat;
  assign RegRData   = page;
  assign DmaActive  = act;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      page  <= '0;
      idx   <= '0;
      dly   <= '0;
      cyc   <= 1'b0;
      adr   <= '0;
      we    <= 1'b0;
      oadr  <= '0;
      odat  <= '0;
      act   <= 1'b0;
    end else begin
      we <= 1'b0;
      // A register write wins over everything: it drops any read in
      // flight (late ack falls on a non-READ state) and rearms.
      if (RegWe) begin
        page  <= RegWData;
        idx   <= '0;
        dly   <= '0;
        cyc   <= 1'b0;
        act   <= 1'b1;
        state <= ARM;
      end else begin
        unique case (state)
          IDLE: ;
          ARM: begin
            if (ClkEn) begin
              if (dly == DLY_LAST) begin
                cyc   <= 1'b1;
                adr   <= {oam_dma_src_page(page), idx};
                state <= READ;
              end else begin
                dly <= dly + 8'd1;
              end
            end
          end
          READ: begin
            if (bus.SrcAck) begin
              cyc   <= 1'b0;
              we    <= 1'b1;
              oadr  <= idx;
              odat  <= bus.SrcDat;
              state <= WRITE;
            end
          end
          WRITE: begin
            if (idx == IDX_LAST) begin
              act   <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= idx + 8'd1;
              state <= WAIT;
            end
          end
          WAIT: begin
            if (ClkEn) begin
              cyc   <= 1'b1;
              adr   <= {oam_dma_src_page(page), idx};
              state <= READ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gbc_oam_dma.sv
// Self-checking bench for gbc_oam_dma: scoreboard of expected OAM writes,
// memory responder with per-byte ack latency, ClkEn every 4 CLK.
module tb_gbc_oam_dma;

  typedef struct {
    logic [7:0] adr;
    logic [7:0] dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       we = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       act;

  gbc_oam_dma_if bus();

  gbc_oam_dma #(
    .OAM_BYTES  (160),
    .START_DELAY(1)
  ) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .ClkEn    (ce),
    .RegWe    (we),
    .RegWData (wdata),
    .RegRData (rdata),
    .DmaActive(act),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;
  int   slow_idx = -1;
  int   slow_lat = 7;
  int   phase = 0;
  exp_t q[$];

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = a[15:8];
    lo = a[7:0];
    return hi * 8'd37 + lo * 8'd11 + 8'h5A;
  endfunction

  function automatic logic [7:0] map_page(input logic [7:0] p);
`ifdef GBC_OAM_DMA_ECHO_EN
    return (p >= 8'hE0) ? p - 8'h20 : p;
`else
    return p;
`endif
  endfunction

  task automatic push_page(input logic [7:0] p);
    q.delete();
    for (int i = 0; i < 160; i++)
      q.push_back('{adr: 8'(i), dat: mem_byte({map_page(p), 8'(i)})});
  endtask

  // ClkEn high one CLK in four
  initial begin
    forever begin
      @(posedge clk);
      #1;
      phase = (phase + 1) % 4;
      ce = (phase == 0);
    end
  end

  // Memory responder: ack after lat cycles of SrcStb
  initial begin
    int wc;
    int lat;
    wc = 0;
    bus.SrcAck = 1'b0;
    bus.SrcDat = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.SrcCyc === 1'b1 && bus.SrcStb === 1'b1) begin
        lat = (int'(bus.SrcAdr[7:0]) == slow_idx) ? slow_lat : 1;
        if (wc == lat) begin
          bus.SrcAck = 1'b1;
          bus.SrcDat = mem_byte(bus.SrcAdr);
        end else begin
          bus.SrcAck = 1'b0;
        end
        wc++;
      end else begin
        bus.SrcAck = 1'b0;
        wc = 0;
      end
    end
  end

  // Scoreboard consumer: every OamWe pops one expected write
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.OamWe === 1'b1) begin
        wr_cnt++;
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL oam_extra: adr=%h dat=%h, expected none",
                   bus.OamAdr, bus.OamDat);
        end else begin
          e = q.pop_front();
          if (bus.OamAdr !== e.adr || bus.OamDat !== e.dat) begin
            n_fail++;
            $display("FAIL oam_write: adr=%h dat=%h, expected %h %h",
                     bus.OamAdr, bus.OamDat, e.adr, e.dat);
          end
        end
      end
    end
  end

  task automatic do_write(input logic [7:0] p);
    @(negedge clk);
    while (ce !== 1'b1) @(negedge clk);
    we = 1'b1;
    wdata = p;
    push_page(p);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (act === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (act !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: DmaActive=%b, required 0", nm, act);
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_left: %0d writes missing, required 0",
               nm, q.size());
    end
  endtask

  task automatic wait_rd(input logic [7:0] i, input string nm);
    int n;
    n = 0;
    while (!(bus.SrcCyc === 1'b1 && bus.SrcAdr[7:0] == i) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (bus.SrcCyc !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_rd_timeout: SrcCyc=%b, required 1",
               nm, bus.SrcCyc);
    end
  endtask

  task automatic test_reset();
    logic [44:0] o;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    o = {bus.SrcCyc, bus.SrcStb, bus.SrcAdr, bus.OamWe,
         bus.OamAdr, bus.OamDat, act, rdata};
    n_chk++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: %h, required 0", o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    int nce;
    int first;
    wr_cnt = 0;
    @(negedge clk);
    while (ce !== 1'b1) @(negedge clk);
    we = 1'b1;
    wdata = 8'hC1;
    push_page(8'hC1);
    nce = 1;
    @(negedge clk);
    we = 1'b0;
    n_chk++;
    if (act !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_active_t1: %b, required 1", act);
    end
    n_chk++;
    if (rdata !== 8'hC1) begin
      n_fail++;
      $display("FAIL basic_readback: %h, required c1", rdata);
    end
    n = 0;
    first = -1;
    while (act === 1'b1 && n < 3000) begin
      if (ce === 1'b1) nce++;
      if (bus.SrcCyc === 1'b1 && first < 0) begin
        first = n + 1;
        n_chk++;
        if (bus.SrcAdr !== 16'hC100) begin
          n_fail++;
          $display("FAIL basic_first_adr: %h, required c100",
                   bus.SrcAdr);
        end
      end
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (first != 5) begin
      n_fail++;
      $display("FAIL basic_first_read: cycle %0d, required 5", first);
    end
    n_chk++;
    if (nce != 161) begin
      n_fail++;
      $display("FAIL basic_clken_span: %0d, required 161", nce);
    end
    n_chk++;
    if (wr_cnt != 160) begin
      n_fail++;
      $display("FAIL basic_writes: %0d, required 160", wr_cnt);
    end
    wait_idle("basic");
  endtask

  task automatic test_restart();
    wr_cnt = 0;
    do_write(8'h80);
    wait_rd(8'd50, "restart");
    n_chk++;
    if (wr_cnt != 50) begin
      n_fail++;
      $display("FAIL restart_pre_writes: %0d, required 50", wr_cnt);
    end
    we = 1'b1;
    wdata = 8'hC0;
    push_page(8'hC0);
    wr_cnt = 0;
    @(negedge clk);
    we = 1'b0;
    n_chk++;
    if (bus.SrcCyc !== 1'b0 || act !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_drop: cyc=%b act=%b, required 0 1",
               bus.SrcCyc, act);
    end
    wait_idle("restart");
    n_chk++;
    if (wr_cnt != 160) begin
      n_fail++;
      $display("FAIL restart_writes: %0d, required 160", wr_cnt);
    end
  endtask

  task automatic test_slow_ack();
    int n;
    bit early;
    wr_cnt = 0;
    slow_idx = 10;
    do_write(8'hC1);
    wait_rd(8'd10, "slow");
    n = 0;
    early = 1'b0;
    while (bus.SrcStb === 1'b1 && n < 50) begin
      if (bus.OamWe === 1'b1) early = 1'b1;
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL slow_stb_hold: %0d cycles, required 8", n);
    end
    n_chk++;
    if (early) begin
      n_fail++;
      $display("FAIL slow_early_we: 1, required 0");
    end
    n_chk++;
    if (bus.OamWe !== 1'b1 || bus.OamAdr !== 8'd10) begin
      n_fail++;
      $display("FAIL slow_write_after_ack: we=%b adr=%h, required 1 0a",
               bus.OamWe, bus.OamAdr);
    end
    wait_idle("slow");
    slow_idx = -1;
    n_chk++;
    if (wr_cnt != 160) begin
      n_fail++;
      $display("FAIL slow_writes: %0d, required 160", wr_cnt);
    end
  endtask

  task automatic test_echo();
    logic [7:0]  hi;
    logic [15:0] last;
    int n;
`ifdef GBC_OAM_DMA_ECHO_EN
    hi = 8'hDE;
`else
    hi = 8'hFE;
`endif
    do_write(8'hFE);
    wait_rd(8'd0, "echo");
    n_chk++;
    if (bus.SrcAdr !== {hi, 8'h00}) begin
      n_fail++;
      $display("FAIL echo_first_adr: %h, required %h",
               bus.SrcAdr, {hi, 8'h00});
    end
    last = '0;
    n = 0;
    while (act === 1'b1 && n < 3000) begin
      if (bus.SrcCyc === 1'b1) last = bus.SrcAdr;
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (last !== {hi, 8'h9F}) begin
      n_fail++;
      $display("FAIL echo_last_adr: %h, required %h",
               last, {hi, 8'h9F});
    end
    n_chk++;
    if (rdata !== 8'hFE) begin
      n_fail++;
      $display("FAIL echo_readback: %h, required fe", rdata);
    end
    wait_idle("echo");
  endtask

  task automatic test_rst_mid();
    logic [44:0] o;
    bit busy;
    do_write(8'hC1);
    wait_rd(8'd80, "rstmid");
    #2;
    rst_n = 1'b0;
    #1;
    o = {bus.SrcCyc, bus.SrcStb, bus.SrcAdr, bus.OamWe,
         bus.OamAdr, bus.OamDat, act, rdata};
    n_chk++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: %h, required 0", o);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wr_cnt = 0;
    busy = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.SrcCyc !== 1'b0 || act !== 1'b0) busy = 1'b1;
    end
    n_chk++;
    if (busy || wr_cnt != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: busy=%b writes=%0d, required 0 0",
               busy, wr_cnt);
    end
  endtask

  task automatic test_coincident();
    wr_cnt = 0;
    do_write(8'hC1);
    wait_rd(8'd159, "coinc");
    @(negedge clk);
    we = 1'b1;
    wdata = 8'h90;
    #1;
    n_chk++;
    if (bus.SrcAck !== 1'b1) begin
      n_fail++;
      $display("FAIL coinc_ack_aligned: %b, required 1", bus.SrcAck);
    end
    push_page(8'h90);
    @(negedge clk);
    we = 1'b0;
    n_chk++;
    if (bus.OamWe !== 1'b0 || act !== 1'b1) begin
      n_fail++;
      $display("FAIL coinc_no_write: we=%b act=%b, required 0 1",
               bus.OamWe, act);
    end
    wait_idle("coinc");
    n_chk++;
    if (wr_cnt != 319) begin
      n_fail++;
      $display("FAIL coinc_writes: %0d, required 319", wr_cnt);
    end
    n_chk++;
    if (rdata !== 8'h90) begin
      n_fail++;
      $display("FAIL coinc_readback: %h, required 90", rdata);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_slow_ack();
    test_echo();
    test_rst_mid();
    test_coincident();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gbc_oam_dma.md
# gbc_oam_dma

OAM DMA engine for the GBC video subsystem: on a CPU write to $FF46 it copies 160 bytes from source page `XX00-XX9F` into OAM `$FE00-$FE9F`, one byte per ClkEn-qualified machine cycle. It sits directly upstream of the video PPU's OAM port, between the system bus and the PPU. It asserts `DmaActive` so the memory controller locks the CPU off the bus during the copy.

## Interface
Parameters:
- `OAM_BYTES`, 160, bytes transferred per DMA.
- `START_DELAY`, 1, ClkEn pulses between the register write and the first source read.

Ports:
- `CLK` in 1: system clock.
- `RST` in 1: reset, asynchronous, active-low.
- `ClkEn` in 1: machine-cycle enable, shared with the CPU.
- `RegWe` in 1: write strobe for $FF46, single cycle.
- `RegWData` in 8: source page written to $FF46.
- `RegRData` out 8: last page written, for readback.
- `SrcCyc`, `SrcStb` out 1: Wishbone read request to system memory.
- `SrcAdr` out 16: source byte address.
- `SrcAck` in 1: read acknowledge.
- `SrcDat` in 8: read data, valid with `SrcAck`.
- `OamWe` out 1: OAM write strobe, single cycle.
- `OamAdr` out 8: OAM index, 0-159.
- `OamDat` out 8: OAM write data.
- `DmaActive` out 1: transfer in progress; the bus arbiter blocks the CPU and the PPU treats OAM as busy.

## Operation
- The state machine has five states: IDLE, ARM, READ, WRITE and WAIT.
- **IDLE:** `RegWe` latches `RegWData` into the page register, clears the index, and moves to ARM.
- **ARM:** counts `START_DELAY` ClkEn pulses, then goes to READ.
  - `DmaActive` rises on entry to ARM.
- **READ:** holds `SrcCyc`/`SrcStb` high with `SrcAdr = {page, index}` until `SrcAck`, captures `SrcDat`, then goes to WRITE.
  - Waiting for acknowledge has no timeout.
- **WRITE:** pulses `OamWe` for one CLK with `OamAdr = index`.
  - If index = 159, go to IDLE.
  - Otherwise increment the index and go to WAIT.
- **WAIT:** on the next ClkEn, go to READ.
- **Restart:** `RegWe` in any non-IDLE state relatches the page, clears the index and goes to ARM.
  - Any read in flight is dropped: `SrcCyc` deasserts immediately and the late ack is ignored.
  - No OAM write is issued for the aborted byte.
  - `DmaActive` stays high throughout.
- **Simultaneous events:** `RegWe` in the same cycle as `SrcAck`/WRITE takes priority. The byte is discarded and the restart happens.
- **Reset:** `RST` low at any point returns to IDLE and the machine produces no further output.
  - Reset values: page = 0, index = 0, `DmaActive` = 0, `SrcCyc` = `SrcStb` = 0, `OamWe` = 0, `SrcAdr` = 0, `OamAdr` = 0, `OamDat` = 0, `RegRData` = 0.
- **Index arithmetic:** 8-bit index, range 0..159, never wraps past 159. `SrcAdr[7:0] = index`.

## Timing
- `RegWe` at cycle T: ARM is entered at T+1 and `DmaActive` is high from T+1.
- Byte n's read is issued the CLK after the (START_DELAY + n)-th ClkEn following T.
- WRITE follows the ack cycle by exactly one CLK.
- With ack in one cycle and ClkEn every 4 CLK, one byte transfers per 4 CLK.
  - Total time is 160 ClkEn pulses plus the start delay.
- `DmaActive` falls the CLK after the WRITE of index 159.
- `RegRData` updates the CLK after `RegWe`.

## Configuration
- Macro `GBC_OAM_DMA_ECHO_EN`, when defined: a source page ≥ $E0 is remapped to page − $20 (echo RAM), so $FE00 reads $DE00.
  - The remap is applied to `SrcAdr[15:8]` only; `RegRData` keeps the unmapped value.
- When undefined: the page is used verbatim on `SrcAdr`.

## Structure
- Package `gbc_video_pkg` holds:
  - `typedef enum` `oam_dma_state_t` (IDLE, ARM, READ, WRITE, WAIT);
  - constants `OAM_DMA_REG_ADDR = 8'h46` and `OAM_BASE = 16'hFE00`;
  - function `oam_dma_src_page()` implementing the echo remap.
- Single flat module; no sub-module is warranted.

## Test plan
- Write $C1, ClkEn every 4 CLK, ack after 1 cycle -> 160 `OamWe` pulses.
  - `OamAdr` runs 0..159 and `OamDat` equals memory[$C100+i].
  - `DmaActive` lasts 161 ClkEn pulses.
- Write $80, then write $C0 during byte 50 -> no write occurs for index 50 from page $80.
  - Transfer restarts at index 0 from $C000.
  - Exactly 160 writes follow the restart.
  - `DmaActive` never drops.
- Ack delayed by 7 CLK on byte 10 -> `SrcStb` is held for those 7 CLK.
  - No `OamWe` is issued until the ack.
  - Ordering is preserved.
- Write $FE with `GBC_OAM_DMA_ECHO_EN` -> `SrcAdr` = $DE00..$DE9F.
  - Without the macro -> $FE00..$FE9F.
- Assert `RST` low at byte 80 -> all outputs are 0 within the same cycle.
  - After release, no activity occurs until the next `RegWe`.
- `RegWe` coincident with `SrcAck` on byte 159 -> no `OamWe` for byte 159 and the restart is taken.
